gcd_arbiter: RTL and testbench

// Shares one GCD engine (32-bit operand in / 16-bit result out, valid/ready in,

---
 rtl/gcd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD engine among NUM_REQ
// requesters. It latches the winner's operands, drives the engine's valid/ready
// input, waits for the engine's one-cycle result pulse and returns the result
// tagged with the requester id. Operands with a == 0 are answered directly
// (gcd(0,b) = b) because the engine never completes them. A watchdog moves the
// block into a sticky HANG state if the engine stays silent for too long.
module gcd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 70000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_data,
    input  logic                  resp_ready,
    output logic                  gcd_in_valid,
    output logic [31:0]           gcd_in_data,
    input  logic                  gcd_in_ready,
    input  logic                  gcd_out_valid,
    input  logic [15:0]           gcd_out_data,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP,
        S_HANG
    } state_t;

    localparam int               CNT_W    = 17;
    // Value of the BUSY counter in the last BUSY cycle allowed before HANG.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [31:0]       r_op;
    logic [15:0]       r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W:0]     w_sum;
    logic [31:0]       w_sel_data;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[ID_W-1:0];
            end
        end
    end

    // Operand mux selecting the winning requester's 32-bit word.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_data = req_data[32*i +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next       = r_state;
        req_ready    = '0;
        resp_valid   = 1'b0;
        gcd_in_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    // a == 0 never finishes in the engine; answer it locally.
                    w_next = (w_sel_data[15:0] == 16'd0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                gcd_in_valid = 1'b1;
                if (gcd_in_ready) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // A result pulse wins over a watchdog expiry in the same cycle.
                if (gcd_out_valid) begin
                    w_next = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_HANG;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_HANG: begin
                w_next = S_HANG;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand/result/id latches, round-robin pointer, watchdog counter and error flag.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath registers are reset too, so resp_id/resp_data read 0 straight out of reset.
        if (reset) begin
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op     <= w_sel_data;
                        r_id     <= w_winner;
                        r_rr_ptr <= w_winner;
                        if (w_sel_data[15:0] == 16'd0) begin
                            r_result <= w_sel_data[31:16];
                        end
                    end
                end
                S_ISSUE: begin
                    if (gcd_in_ready) begin
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (gcd_out_valid) begin
                        r_result <= gcd_out_data;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_id     = r_id;
    assign resp_data   = r_result;
    assign gcd_in_data = r_op;
    assign err         = r_err;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter: four requesters fed from per-requester operand
// queues, a behavioural GCD engine with random latency and input stalls, and a
// scoreboard of expected (id, gcd) pairs checked by a separate monitor.
module tb_gcd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 20;

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_data;
    logic                  resp_ready;
    logic                  gcd_in_valid;
    logic [31:0]           gcd_in_data;
    logic                  gcd_in_ready;
    logic                  gcd_out_valid;
    logic [15:0]           gcd_out_data;
    logic                  err;

    gcd_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .gcd_in_valid (gcd_in_valid),
        .gcd_in_data  (gcd_in_data),
        .gcd_in_ready (gcd_in_ready),
        .gcd_out_valid(gcd_out_valid),
        .gcd_out_data (gcd_out_data),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fail_wait(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Reference: Euclid's algorithm; gcd(0,b)=b and gcd(0,0)=0 fall out naturally.
    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Round-robin reference: first valid index after the previous winner.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (v[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
        end
        return -1;
    endfunction

    // ---------------- behavioural GCD engine ----------------
    bit          hang_mode = 1'b0;
    bit          stall_en  = 1'b0;
    logic        eng_busy;
    logic        eng_stall;
    int          eng_left;
    logic [15:0] eng_res;

    assign gcd_in_ready = !eng_busy && !eng_stall;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_busy      <= 1'b0;
            eng_stall     <= 1'b0;
            eng_left      <= 0;
            eng_res       <= '0;
            gcd_out_valid <= 1'b0;
            gcd_out_data  <= '0;
        end else begin
            gcd_out_valid <= 1'b0;
            eng_stall     <= stall_en && ($urandom_range(0, 3) == 0);
            if (!eng_busy) begin
                if (gcd_in_valid && gcd_in_ready) begin
                    eng_busy <= 1'b1;
                    eng_left <= int'($urandom_range(1, 6));
                    eng_res  <= 16'(ref_gcd(gcd_in_data[15:0], gcd_in_data[31:16]));
                end
            end else if (!hang_mode) begin
                if (eng_left == 1) begin
                    gcd_out_valid <= 1'b1;
                    gcd_out_data  <= eng_res;
                    eng_busy      <= 1'b0;
                end else begin
                    eng_left <= eng_left - 1;
                end
            end
        end
    end

    // ---------------- requester / consumer driver ----------------
    logic [31:0] q_ops [NUM_REQ][$];
    int          bp_mode = 0;  // 0: resp_ready=1, 1: resp_ready=0, 2: random

    initial begin
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (q_ops[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[32*i +: 32] = q_ops[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            case (bp_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'b0;
                default: resp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        int          id;
        int unsigned data;
        bit          bypass;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          model_ptr      = NUM_REQ - 1;
    int          n_issues       = 0;
    int          n_grants       = 0;
    int          issue_cyc      = 0;
    int          pulse_cyc      = 0;
    int          hs_cyc         = 0;
    int          err_cyc        = 0;
    int          last_grant_gap = 0;
    int          rr1_hi         = 0;
    bit          err_seen       = 1'b0;
    bit          resp_seen      = 1'b0;
    bit          prev_in_stall  = 1'b0;
    logic [31:0] prev_in_data   = '0;
    logic [31:0] last_issue_data = '0;
    int          last_id        = -1;
    int          last_data      = -1;

    always @(negedge clk) begin
        exp_t        e;
        int          g;
        logic [31:0] op;
        if (!reset) begin
            if (prev_in_stall) begin
                check("in_valid_held", gcd_in_valid, 1);
                check("in_data_held", gcd_in_data, prev_in_data);
            end
            prev_in_stall = gcd_in_valid && !gcd_in_ready;
            prev_in_data  = gcd_in_data;
            if (gcd_in_valid && gcd_in_ready) begin
                n_issues++;
                last_issue_data = gcd_in_data;
                issue_cyc = cyc;
                check("issue_a_nonzero", gcd_in_data[15:0] != 16'd0, 1);
            end
            if (gcd_out_valid) pulse_cyc = cyc;
            if (err && !err_seen) begin
                err_seen = 1'b1;
                err_cyc  = cyc;
            end
            if (req_ready[1]) rr1_hi++;

            if (req_ready != '0) begin
                check("req_ready_onehot", $countones(req_ready), 1);
                check("req_ready_subset", req_ready & ~req_valid, 0);
                g = -1;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
                check("grant_rr_order", g, rr_pick(req_valid, model_ptr));
                model_ptr = g;
                n_grants++;
                last_grant_gap = cyc - hs_cyc;
                grant_log.push_back(g);
                if (q_ops[g].size() > 0) begin
                    op        = q_ops[g].pop_front();
                    e.id      = g;
                    e.data    = ref_gcd(op[15:0], op[31:16]);
                    e.bypass  = (op[15:0] == 16'd0);
                    e.acc_cyc = cyc;
                    sb.push_back(e);
                end
            end

            if (resp_valid && !resp_seen) begin
                resp_seen = 1'b1;
                if (sb.size() > 0) begin
                    check("resp_latency", cyc, sb[0].bypass ? sb[0].acc_cyc + 1 : pulse_cyc + 1);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_data", resp_data, e.data);
                end
                last_id   = resp_id;
                last_data = resp_data;
                hs_cyc    = cyc;
                resp_seen = 1'b0;
            end
        end
    end

    // ---------------- helper tasks ----------------
    task automatic check_outputs_idle(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_gcd_in_valid"}, gcd_in_valid, 0);
        check({tag, "_resp_id"}, resp_id, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) q_ops[i].delete();
        sb.delete();
        model_ptr     = NUM_REQ - 1;
        resp_seen     = 1'b0;
        prev_in_stall = 1'b0;
        err_seen      = 1'b0;
        hang_mode     = 1'b0;
        #1;
        check_outputs_idle(tag);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        bit pending = 1'b1;
        while (pending && k < 3000) begin
            @(negedge clk);
            k++;
            pending = (sb.size() != 0) || resp_valid;
            for (int i = 0; i < NUM_REQ; i++) if (q_ops[i].size() != 0) pending = 1'b1;
        end
        if (pending) fail_wait(tag);
    endtask

    task automatic wait_issue(input int n0, input string tag);
        int k = 0;
        while (n_issues == n0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (n_issues == n0) fail_wait(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          n_iss0;
        int          n_gr0;
        int          k;
        int          cap_id;
        int          cap_data;
        int          exp_order[5];
        logic [15:0] ra;
        logic [15:0] rb;

        exp_order = '{0, 1, 2, 3, 0};
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_idle("por");
        reset = 1'b0;

        // Reset while the engine is busy, then a normal op from requester 0.
        hang_mode = 1'b1;
        n_iss0 = n_issues;
        q_ops[1].push_back(32'h0007_0003);
        wait_issue(n_iss0, "midbusy_issue");
        repeat (3) @(negedge clk);
        do_reset("midbusy_rst");
        q_ops[0].push_back(32'h0012_000C);
        wait_idle("after_reset_op");
        check("after_reset_id", last_id, 0);
        check("after_reset_data", last_data, 6);

        // Single request from requester 1 through the engine.
        rr1_hi = 0;
        n_iss0 = n_issues;
        q_ops[1].push_back(32'h0015_000E);
        wait_idle("single_req1");
        check("single_issue_data", last_issue_data, 32'h0015_000E);
        check("single_id", last_id, 1);
        check("single_data", last_data, 7);
        check("single_ready_pulse", rr1_hi, 1);
        check("single_issue_count", n_issues - n_iss0, 1);

        // All four requesters contending.
        do_reset("rr_rst");
        grant_log.delete();
        q_ops[0].push_back(32'h0009_0006);
        q_ops[0].push_back(32'h0009_0006);
        for (int i = 1; i < NUM_REQ; i++) q_ops[i].push_back(32'h0009_0006);
        wait_idle("rr_all");
        check("rr_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_grant_seq", grant_log[i], exp_order[i]);
        check("rr_last_data", last_data, 3);

        // a == 0 bypass path.
        n_iss0 = n_issues;
        q_ops[2].push_back(32'h0005_0000);
        wait_idle("bypass5");
        check("bypass5_id", last_id, 2);
        check("bypass5_data", last_data, 5);
        q_ops[2].push_back(32'h0000_0000);
        wait_idle("bypass0");
        check("bypass0_data", last_data, 0);
        check("bypass_no_issue", n_issues, n_iss0);

        // Result backpressure.
        bp_mode = 1;
        q_ops[3].push_back(32'h000C_0009);
        k = 0;
        while (!resp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!resp_valid) fail_wait("bp_resp");
        cap_id   = resp_id;
        cap_data = resp_data;
        check("bp_id", cap_id, 3);
        check("bp_data", cap_data, 3);
        q_ops[0].push_back(32'h000F_000A);
        n_iss0 = n_issues;
        n_gr0  = n_grants;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid_held", resp_valid, 1);
            check("bp_id_held", resp_id, cap_id);
            check("bp_data_held", resp_data, cap_data);
            check("bp_no_grant", req_ready, 0);
        end
        check("bp_no_reissue", n_issues, n_iss0);
        check("bp_grants_frozen", n_grants, n_gr0);
        bp_mode = 0;
        k = 0;
        while (n_grants == n_gr0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (n_grants == n_gr0) fail_wait("bp_next_grant");
        check("bp_grant_gap", last_grant_gap, 1);
        wait_idle("bp_drain");
        check("bp_drain_data", last_data, 5);

        // Randomized traffic with engine input stalls and consumer backpressure.
        stall_en = 1'b1;
        bp_mode  = 2;
        for (int n = 0; n < 60; n++) begin
            ra = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            rb = 16'($urandom_range(0, 300));
            q_ops[$urandom_range(0, NUM_REQ - 1)].push_back({rb, ra});
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bp_mode = 0;
        wait_idle("random_drain");
        stall_en = 1'b0;
        check("random_no_err", err, 0);

        // Watchdog: engine accepts but never answers.
        hang_mode = 1'b1;
        n_iss0 = n_issues;
        q_ops[1].push_back(32'h0003_0002);
        wait_issue(n_iss0, "wd_issue");
        k = 0;
        while (!err_seen && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!err_seen) fail_wait("wd_err");
        check("wd_busy_cycles", err_cyc - issue_cyc - 1, TIMEOUT);
        q_ops[2].push_back(32'h0004_0002);
        repeat (10) begin
            @(negedge clk);
            check("hang_err", err, 1);
            check("hang_req_ready", req_ready, 0);
            check("hang_resp_valid", resp_valid, 0);
            check("hang_in_valid", gcd_in_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
